// File: rtl/lane_queue_tracker_if.sv
// Bundles the per-lane traffic signals of lane_queue_tracker.
//   master : traffic controller side; drives arrive/green/hold/clrOvf and
//            reads the queue status.
//   slave  : the tracker; reads the controls and drives the status.
// Signals
//   arrive[7:0]      one-cycle car-arrival strobe per lane
//   green[7:0]       per-lane green light, 1 = lane may discharge
//   hold             freezes all departures; arrivals still count
//   clrOvf           synchronous clear of all overflow flags
//   laneCounts[63:0] packed queue lengths, lane i in bits [8i+7:8i]
//   departPulse[7:0] one-cycle pulse per lane decrement
//   emptyFlags[7:0]  bit i = lane i queue is empty
//   overflow[7:0]    sticky per-lane dropped-arrival flag
//   maxLane[2:0]     index of the longest queue
//   maxCount[7:0]    length of that queue
interface lane_queue_tracker_if;
    logic [7:0]  arrive;
    logic [7:0]  green;
    logic        hold;
    logic        clrOvf;
    logic [63:0] laneCounts;
    logic [7:0]  departPulse;
    logic [7:0]  emptyFlags;
    logic [7:0]  overflow;
    logic [2:0]  maxLane;
    logic [7:0]  maxCount;

    modport master (
        output arrive, green, hold, clrOvf,
        input  laneCounts, departPulse, emptyFlags, overflow, maxLane, maxCount
    );

    modport slave (
        input  arrive, green, hold, clrOvf,
        output laneCounts, departPulse, emptyFlags, overflow, maxLane, maxCount
    );
endinterface

// File: rtl/lane_queue_tracker.sv
// Per-lane car queue tracker for an 8-lane intersection.
// Each lane counts arrivals and, while its light is green, discharges one car
// every DEPART_CYCLES clock edges. Counts saturate at MAX_COUNT with a sticky
// overflow flag. The longest queue and its length are reported one cycle late.
// Ports
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  lane_queue_tracker_if slave modport (controls in, status out)
module lane_queue_tracker #(
    parameter int unsigned DEPART_CYCLES = 2,
    parameter int unsigned MAX_COUNT     = 255
) (
    input logic                  clk,
    input logic                  rst,
    lane_queue_tracker_if.slave  bus
);

    localparam logic [3:0] TMR_LAST = 4'(DEPART_CYCLES - 1);
    localparam logic [7:0] CEIL     = 8'(MAX_COUNT);

    logic [7:0] count [8];
    logic [3:0] tmr   [8];
    logic [7:0] count_nxt [8];
    logic [3:0] tmr_nxt   [8];

    logic [7:0] eligible;
    logic [7:0] depart;
    logic [7:0] drop;

    logic [7:0] pulse_q;
    logic [7:0] ovf_q;
    logic [2:0] max_lane_q;
    logic [7:0] max_count_q;

    logic [2:0] best_idx;
    logic [7:0] best_cnt;

    always_comb begin
        eligible = '0;
        depart   = '0;
        drop     = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            count_nxt[i] = count[i];
            tmr_nxt[i]   = '0;

            eligible[i] = bus.green[i] & ~bus.hold & (count[i] != '0);
            depart[i]   = eligible[i] & (tmr[i] == TMR_LAST);
            drop[i]     = bus.arrive[i] & ~depart[i] & (count[i] == CEIL);

            // Arrival and departure on the same edge cancel out.
            if (bus.arrive[i] && !depart[i] && !drop[i]) begin
                count_nxt[i] = count[i] + 8'd1;
            end else if (!bus.arrive[i] && depart[i]) begin
                count_nxt[i] = count[i] - 8'd1;
            end

            // Hold freezes a partially elapsed timer; any other loss of
            // eligibility restarts it.
            if (eligible[i]) begin
                tmr_nxt[i] = depart[i] ? '0 : tmr[i] + 4'd1;
            end else if (bus.hold) begin
                tmr_nxt[i] = tmr[i];
            end
        end
    end

    // Strict '>' scan from lane 0 keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_cnt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (count[i] > best_cnt) begin
                best_cnt = count[i];
                best_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                count[i] <= '0;
                tmr[i]   <= '0;
            end
            pulse_q     <= '0;
            ovf_q       <= '0;
            max_lane_q  <= '0;
            max_count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                count[i] <= count_nxt[i];
                tmr[i]   <= tmr_nxt[i];
            end
            pulse_q     <= depart;
            // A new drop on the clearing edge still sets its flag.
            ovf_q       <= (ovf_q & ~{8{bus.clrOvf}}) | drop;
            max_lane_q  <= best_idx;
            max_count_q <= best_cnt;
        end
    end

    always_comb begin
        bus.laneCounts = '0;
        bus.emptyFlags = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            bus.laneCounts[8*i +: 8] = count[i];
            bus.emptyFlags[i]        = (count[i] == '0);
        end
    end

    assign bus.departPulse = pulse_q;
    assign bus.overflow    = ovf_q;
    assign bus.maxLane     = max_lane_q;
    assign bus.maxCount    = max_count_q;

endmodule

// File: tb/tb_lane_queue_tracker.sv
// Directed bench for lane_queue_tracker (DEPART_CYCLES=2, MAX_COUNT=255).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_lane_queue_tracker;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    lane_queue_tracker_if bus ();

    lane_queue_tracker #(.DEPART_CYCLES(2), .MAX_COUNT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.arrive = '0;
        bus.green  = '0;
        bus.hold   = 1'b0;
        bus.clrOvf = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [7:0] lane_cnt(input int i);
        return bus.laneCounts[8*i +: 8];
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #2;
        n_cmp++; if (bus.laneCounts !== 64'h0) begin n_bad++; $display("FAIL reset_counts got %h exp 0", bus.laneCounts); end
        n_cmp++; if (bus.emptyFlags !== 8'hFF) begin n_bad++; $display("FAIL reset_empty got %h exp ff", bus.emptyFlags); end
        n_cmp++; if (bus.departPulse !== 8'h00) begin n_bad++; $display("FAIL reset_pulse got %h exp 00", bus.departPulse); end
        n_cmp++; if (bus.overflow !== 8'h00) begin n_bad++; $display("FAIL reset_ovf got %h exp 00", bus.overflow); end
        n_cmp++; if (bus.maxLane !== 3'd0) begin n_bad++; $display("FAIL reset_maxlane got %0d exp 0", bus.maxLane); end
        n_cmp++; if (bus.maxCount !== 8'd0) begin n_bad++; $display("FAIL reset_maxcount got %0d exp 0", bus.maxCount); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_arrive_max();
        apply_reset();
        bus.arrive = 8'h80;
        tick();
        tick();
        n_cmp++; if (bus.maxLane !== 3'd7 || bus.maxCount !== 8'd1) begin n_bad++; $display("FAIL max_lag2 got %0d/%0d exp 7/1", bus.maxLane, bus.maxCount); end
        tick();
        bus.arrive = '0;
        n_cmp++; if (lane_cnt(7) !== 8'd3) begin n_bad++; $display("FAIL w1_count got %0d exp 3", lane_cnt(7)); end
        n_cmp++; if (bus.emptyFlags !== 8'h7F) begin n_bad++; $display("FAIL w1_empty got %h exp 7f", bus.emptyFlags); end
        n_cmp++; if (bus.maxCount !== 8'd2) begin n_bad++; $display("FAIL max_lag3 got %0d exp 2", bus.maxCount); end
        tick();
        n_cmp++; if (bus.maxLane !== 3'd7 || bus.maxCount !== 8'd3) begin n_bad++; $display("FAIL max_final got %0d/%0d exp 7/3", bus.maxLane, bus.maxCount); end
    endtask

    task automatic test_depart();
        logic [7:0] exp_cnt;
        logic       exp_pulse;
        apply_reset();
        bus.arrive = 8'h01;
        repeat (4) tick();
        bus.arrive = '0;
        bus.green  = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_cnt   = (k >= 8) ? 8'd0 : 8'(4 - k / 2);
            exp_pulse = (k % 2 == 0) && (k <= 8);
            n_cmp++; if (lane_cnt(0) !== exp_cnt) begin n_bad++; $display("FAIL depart_cnt edge %0d got %0d exp %0d", k, lane_cnt(0), exp_cnt); end
            n_cmp++; if (bus.departPulse[0] !== exp_pulse) begin n_bad++; $display("FAIL depart_pulse edge %0d got %b exp %b", k, bus.departPulse[0], exp_pulse); end
        end
        n_cmp++; if (bus.emptyFlags[0] !== 1'b1) begin n_bad++; $display("FAIL depart_empty got %b exp 1", bus.emptyFlags[0]); end
        // Timer must be back at 0: a new car needs two full edges of green.
        bus.arrive = 8'h01;
        tick();
        bus.arrive = '0;
        tick();
        n_cmp++; if (lane_cnt(0) !== 8'd1 || bus.departPulse[0] !== 1'b0) begin n_bad++; $display("FAIL tmr_zero_a got %0d/%b exp 1/0", lane_cnt(0), bus.departPulse[0]); end
        tick();
        n_cmp++; if (lane_cnt(0) !== 8'd0 || bus.departPulse[0] !== 1'b1) begin n_bad++; $display("FAIL tmr_zero_b got %0d/%b exp 0/1", lane_cnt(0), bus.departPulse[0]); end
    endtask

    task automatic test_overflow();
        apply_reset();
        bus.arrive = 8'h08;
        repeat (255) tick();
        n_cmp++; if (lane_cnt(3) !== 8'd255 || bus.overflow !== 8'h00) begin n_bad++; $display("FAIL ovf_fill got %0d/%h exp 255/00", lane_cnt(3), bus.overflow); end
        tick();
        n_cmp++; if (lane_cnt(3) !== 8'd255) begin n_bad++; $display("FAIL ovf_sat got %0d exp 255", lane_cnt(3)); end
        n_cmp++; if (bus.overflow !== 8'h08) begin n_bad++; $display("FAIL ovf_set got %h exp 08", bus.overflow); end
        n_cmp++; if (bus.maxLane !== 3'd3 || bus.maxCount !== 8'd255) begin n_bad++; $display("FAIL ovf_max got %0d/%0d exp 3/255", bus.maxLane, bus.maxCount); end
        bus.arrive = '0;
        tick();
        n_cmp++; if (bus.overflow !== 8'h08) begin n_bad++; $display("FAIL ovf_sticky got %h exp 08", bus.overflow); end
        bus.clrOvf = 1'b1;
        tick();
        n_cmp++; if (bus.overflow !== 8'h00) begin n_bad++; $display("FAIL ovf_clear got %h exp 00", bus.overflow); end
        bus.arrive = 8'h08;
        tick();
        bus.arrive = '0;
        bus.clrOvf = 1'b0;
        n_cmp++; if (bus.overflow !== 8'h08) begin n_bad++; $display("FAIL ovf_wins got %h exp 08", bus.overflow); end
    endtask

    task automatic test_arrive_depart();
        apply_reset();
        bus.arrive = 8'h04;
        repeat (3) tick();
        bus.arrive = '0;
        bus.green  = 8'h04;
        tick();
        n_cmp++; if (lane_cnt(2) !== 8'd3 || bus.departPulse !== 8'h00) begin n_bad++; $display("FAIL ad_first got %0d/%h exp 3/00", lane_cnt(2), bus.departPulse); end
        bus.arrive = 8'h04;
        tick();
        bus.arrive = '0;
        n_cmp++; if (lane_cnt(2) !== 8'd3) begin n_bad++; $display("FAIL ad_cancel_cnt got %0d exp 3", lane_cnt(2)); end
        n_cmp++; if (bus.departPulse !== 8'h04) begin n_bad++; $display("FAIL ad_cancel_pulse got %h exp 04", bus.departPulse); end
        tick();
        tick();
        n_cmp++; if (lane_cnt(2) !== 8'd2 || bus.departPulse !== 8'h04) begin n_bad++; $display("FAIL ad_next got %0d/%h exp 2/04", lane_cnt(2), bus.departPulse); end
    endtask

    task automatic test_hold();
        apply_reset();
        bus.arrive = 8'h20;
        repeat (5) tick();
        bus.arrive = '0;
        bus.green  = 8'h20;
        tick();
        bus.hold = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.arrive = (k == 2) ? 8'h02 : 8'h00;
            tick();
            n_cmp++; if (lane_cnt(5) !== 8'd5 || bus.departPulse !== 8'h00) begin n_bad++; $display("FAIL hold_frozen edge %0d got %0d/%h exp 5/00", k, lane_cnt(5), bus.departPulse); end
        end
        bus.arrive = '0;
        n_cmp++; if (lane_cnt(1) !== 8'd1) begin n_bad++; $display("FAIL hold_arrive got %0d exp 1", lane_cnt(1)); end
        bus.hold = 1'b0;
        tick();
        n_cmp++; if (lane_cnt(5) !== 8'd4 || bus.departPulse !== 8'h20) begin n_bad++; $display("FAIL hold_resume got %0d/%h exp 4/20", lane_cnt(5), bus.departPulse); end
    endtask

    task automatic test_tie();
        apply_reset();
        bus.arrive = 8'h24;
        tick();
        bus.arrive = '0;
        tick();
        n_cmp++; if (bus.maxLane !== 3'd2 || bus.maxCount !== 8'd1) begin n_bad++; $display("FAIL tie_low got %0d/%0d exp 2/1", bus.maxLane, bus.maxCount); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.arrive = 8'h42;
        repeat (2) tick();
        bus.arrive = '0;
        bus.green  = 8'h42;
        tick();
        tick();
        tick();
        n_cmp++; if (lane_cnt(1) !== 8'd1 || lane_cnt(6) !== 8'd1) begin n_bad++; $display("FAIL ar_pre got %0d/%0d exp 1/1", lane_cnt(1), lane_cnt(6)); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.laneCounts !== 64'h0) begin n_bad++; $display("FAIL ar_counts got %h exp 0", bus.laneCounts); end
        n_cmp++; if (bus.emptyFlags !== 8'hFF) begin n_bad++; $display("FAIL ar_empty got %h exp ff", bus.emptyFlags); end
        n_cmp++; if (bus.departPulse !== 8'h00 || bus.overflow !== 8'h00) begin n_bad++; $display("FAIL ar_flags got %h/%h exp 00/00", bus.departPulse, bus.overflow); end
        n_cmp++; if (bus.maxLane !== 3'd0 || bus.maxCount !== 8'd0) begin n_bad++; $display("FAIL ar_max got %0d/%0d exp 0/0", bus.maxLane, bus.maxCount); end
        #1;
        rst = 1'b1;
        bus.arrive = 8'h02;
        tick();
        bus.arrive = '0;
        tick();
        n_cmp++; if (lane_cnt(1) !== 8'd1 || bus.departPulse !== 8'h00) begin n_bad++; $display("FAIL ar_fresh_a got %0d/%h exp 1/00", lane_cnt(1), bus.departPulse); end
        tick();
        n_cmp++; if (lane_cnt(1) !== 8'd0 || bus.departPulse !== 8'h02) begin n_bad++; $display("FAIL ar_fresh_b got %0d/%h exp 0/02", lane_cnt(1), bus.departPulse); end
    endtask

    initial begin
        test_reset();
        test_arrive_max();
        test_depart();
        test_overflow();
        test_arrive_depart();
        test_hold();
        test_tie();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
